classify_ctrl: RTL and testbench
================================

# classify_ctrl

Sequencing controller for the network's final classification stage. Accepts the fully-connected layer's ten class scores as a serial valid/ready stream, buffers them, launches the pipelined argmax comparator, and returns the winning class index and score to the host over a valid/ready handshake. It also maintains an image counter and sticky error flags.

## Interface
- NUM_CLASSES, 10, class scores per image
- DATA_W, 54, signed score width
- IDX_W, 4, class index width
- WAIT_LIMIT, 8, maximum cycles in WAIT before timeout
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new image; accepted only in IDLE
- abort  in  1  synchronous; return to IDLE from any state
- busy  out  1  high in every state except IDLE
- score_valid  in  1  score beat valid
- score_in  in  DATA_W  signed score; beats arrive in class order 0..9
- score_ready  out  1  high only in COLLECT
- result_valid  out  1  result available
- result_ready  in  1  host accepts result
- result_class  out  IDX_W  winning class
- result_score  out  DATA_W  score of winning class
- image_count  out  16  completed images; wraps at 65535
- err_overrun  out  1  sticky; score_valid seen in LAUNCH, WAIT or HOLD
- err_timeout  out  1  sticky; argmax done missing

## Operation
- States: IDLE, COLLECT, LAUNCH, WAIT, HOLD.
- IDLE: start goes to COLLECT. On that edge, clear beat counter cnt, err_overrun and err_timeout.
- COLLECT: score_ready=1. Each valid&ready beat writes buf[cnt] and increments cnt. On the beat with cnt==NUM_CLASSES-1, go to LAUNCH.
- LAUNCH: drive am_valid=1 for exactly one cycle to the argmax instance, then go to WAIT. buf stays frozen from LAUNCH until the next start.
- WAIT: count cycles.
  - On am_done: capture result_class=am_index and result_score=buf[am_index], set result_valid, go to HOLD.
  - If the counter reaches WAIT_LIMIT first: set err_timeout, go to IDLE without producing a result.
- HOLD: hold result_valid=1 and stable data until result_ready. On the transfer edge: clear result_valid, increment image_count, go to IDLE.
- start outside IDLE is ignored.
- abort has priority over every transition, including start in IDLE. It clears result_valid and cnt and does not count an image. Error flags keep their value.
- score_valid outside COLLECT is never accepted. In LAUNCH, WAIT or HOLD it sets err_overrun.
- Tie resolution among equal scores is defined by argmax itself. The controller passes the index through unchanged.
- All scores are signed. The buffer read uses the captured index, with no extension or truncation.

## Timing
- Reset values: state IDLE, busy 0, score_ready 0, result_valid 0, result_class 0, result_score 0, image_count 0, err_overrun 0, err_timeout 0, cnt 0.
- argmax reset is synchronous, driven as rst_n = ~rst. rst must therefore be held for at least 2 clk edges.
- Let N be the edge that accepts beat 9:
  - LAUNCH occupies the cycle after N.
  - argmax samples am_valid at edge N+1.
  - am_done is high for one cycle after edge N+5.
  - The controller captures the result at edge N+6.
  - result_valid is high from edge N+6.
- Minimum image period: 1 (start) + 10 (beats) + 1 (LAUNCH) + 5 (WAIT) + 1 (HOLD) = 18 cycles with result_ready tied high.
- If result_ready is already high when result_valid rises, the transfer occurs on the next edge.
- Back-to-back: start may be asserted in the cycle after the HOLD transfer edge.

## Structure
- Shared package classify_pkg holds NUM_CLASSES, DATA_W, IDX_W, the state enum classify_state_t and score_t (signed [DATA_W-1:0]).
- One sub-module: the existing argmax comparator, instantiated once.
  - Its data_in is driven from buf.
  - Its valid_in is am_valid.
  - Its max_index and done outputs feed am_index and am_done.
- The score buffer is a flat register array, with no RAM.

## Test plan
- Scores 0..9 = {5,-3,12,7,0,-20,99,4,1,2}, result_ready=1 → result_class=6, result_score=99, result_valid at edge N+6, image_count=1.
- All-negative scores {-9,-8,-7,-6,-5,-4,-3,-2,-1,-100} with random score_valid gaps → result_class=8, result_score=-1. score_ready is never high outside COLLECT.
- Eleven beats sent back-to-back → 11th beat not accepted, err_overrun=1, result still correct. Next accepted start clears err_overrun.
- result_ready held low 20 cycles → result_valid, result_class and result_score stable throughout. image_count increments only on the transfer edge.
- abort during COLLECT after 4 beats → IDLE next edge, busy=0, image_count unchanged. A following full image produces the correct result.
- rst asserted mid-WAIT for 2 cycles → all outputs at reset values, no stale result_valid. Forced missing am_done → err_timeout=1 after 8 WAIT cycles, IDLE.

Source files
------------

// File: rtl/classify_pkg.sv
// Shared types and constants for the final classification stage.
// Scores are signed; the argmax candidate pairs a class index with its score.
package classify_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 54;
  localparam int IDX_W       = 4;
  localparam int WAIT_LIMIT  = 8;
  localparam int WCNT_W      = $clog2(WAIT_LIMIT);

  typedef logic signed [DATA_W-1:0] score_t;
  typedef score_t score_arr_t [NUM_CLASSES];

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_LAUNCH,
    S_WAIT,
    S_HOLD
  } classify_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    score_t           val;
  } cand_t;

  // a always carries the lower indices, so ties keep the lower class
  function automatic cand_t pick(
    input cand_t a,
    input cand_t b
  );
    return (b.val > a.val) ? b : a;
  endfunction

endpackage

// File: rtl/classify_ctrl_argmax.sv
// Five-stage pipelined argmax over the buffered class scores.
// done pulses four edges after the edge that samples valid_in.
import classify_pkg::*;

module classify_ctrl_argmax (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  score_arr_t       data_in,
  output logic [IDX_W-1:0] max_index,
  output logic             done
);

  cand_t      s1_q [5];
  cand_t      s2_q [3];
  cand_t      s3_q [2];
  cand_t      s4_q;
  logic [3:0] v_q;

  // 10 -> 5 -> 3 -> 2 -> 1 reduction tree
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      s1_q[i] <= pick(
        cand_t'{IDX_W'(2*i), data_in[2*i]},
        cand_t'{IDX_W'(2*i+1), data_in[2*i+1]}
      );
    end
    s2_q[0] <= pick(s1_q[0], s1_q[1]);
    s2_q[1] <= pick(s1_q[2], s1_q[3]);
    s2_q[2] <= s1_q[4];
    s3_q[0] <= pick(s2_q[0], s2_q[1]);
    s3_q[1] <= s2_q[2];
    s4_q    <= pick(s3_q[0], s3_q[1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q       <= '0;
      done      <= 1'b0;
      max_index <= '0;
    end else begin
      v_q       <= {v_q[2:0], valid_in};
      done      <= v_q[3];
      max_index <= s4_q.idx;
    end
  end

endmodule

// File: rtl/classify_ctrl.sv
// Final-stage sequencer: buffers ten scores, runs argmax,
// hands back the winner, counts images and keeps sticky errors.
import classify_pkg::*;

module classify_ctrl (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  input  logic                     score_valid,
  input  logic signed [DATA_W-1:0] score_in,
  output logic                     score_ready,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [IDX_W-1:0]         result_class,
  output logic signed [DATA_W-1:0] result_score,
  output logic [15:0]              image_count,
  output logic                     err_overrun,
  output logic                     err_timeout
);

  classify_state_t   state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [WCNT_W-1:0] wcnt_q;
  score_arr_t        buf_q;
  logic              rv_q;
  logic [IDX_W-1:0]  rclass_q;
  score_t            rscore_q;
  logic [15:0]       img_q;
  logic              ovr_q;
  logic              tmo_q;

  logic             am_valid;
  logic [IDX_W-1:0] am_index;
  logic             am_done;
  logic             beat;
  logic             late_beat;

  assign beat      = (state_q == S_COLLECT) && score_valid;
  assign late_beat = score_valid &&
                     ((state_q == S_LAUNCH) ||
                      (state_q == S_WAIT) ||
                      (state_q == S_HOLD));
  assign am_valid  = (state_q == S_LAUNCH);

  assign busy         = (state_q != S_IDLE);
  assign score_ready  = (state_q == S_COLLECT);
  assign result_valid = rv_q;
  assign result_class = rclass_q;
  assign result_score = rscore_q;
  assign image_count  = img_q;
  assign err_overrun  = ovr_q;
  assign err_timeout  = tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++)
        buf_q[i] <= '0;
    end else if (beat && !abort) begin
      buf_q[cnt_q] <= score_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      rv_q     <= 1'b0;
      rclass_q <= '0;
      rscore_q <= '0;
      img_q    <= '0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      if (late_beat)
        ovr_q <= 1'b1;
      if (abort) begin
        state_q <= S_IDLE;
        rv_q    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_COLLECT;
              cnt_q   <= '0;
              ovr_q   <= 1'b0;
              tmo_q   <= 1'b0;
            end
          end
          S_COLLECT: begin
            if (beat) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == IDX_W'(NUM_CLASSES - 1))
                state_q <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            wcnt_q  <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (am_done) begin
              rclass_q <= am_index;
              rscore_q <= buf_q[am_index];
              rv_q     <= 1'b1;
              state_q  <= S_HOLD;
            end else if (wcnt_q == WCNT_W'(WAIT_LIMIT - 1)) begin
              tmo_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
          S_HOLD: begin
            if (result_ready) begin
              rv_q    <= 1'b0;
              img_q   <= img_q + 16'd1;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  classify_ctrl_argmax u_argmax (
    .clk      (clk),
    .rst_n    (~rst),
    .valid_in (am_valid),
    .data_in  (buf_q),
    .max_index(am_index),
    .done     (am_done)
  );

endmodule

// File: tb/tb_classify_ctrl.sv
// Directed bench for classify_ctrl: each task drives one
// scenario and checks the outputs against hand-computed values.
module tb_classify_ctrl;
  import classify_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic score_valid = 1'b0;
  score_t score_in = '0;
  logic result_ready = 1'b0;
  logic busy;
  logic score_ready;
  logic result_valid;
  logic [IDX_W-1:0] result_class;
  score_t result_score;
  logic [15:0] image_count;
  logic err_overrun;
  logic err_timeout;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  classify_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .score_valid (score_valid),
    .score_in    (score_in),
    .score_ready (score_ready),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_class(result_class),
    .result_score(result_score),
    .image_count (image_count),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic score_arr_t to_s(
    input int v [NUM_CLASSES]
  );
    score_arr_t r;
    for (int i = 0; i < NUM_CLASSES; i++)
      r[i] = score_t'(v[i]);
    return r;
  endfunction

  task automatic start_img;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input score_arr_t s, input bit gaps);
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (gaps) begin
        score_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      score_valid = 1'b1;
      score_in = s[i];
      tick();
    end
    score_valid = 1'b0;
  endtask

  task automatic wait_rv(output int lat);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (result_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    n_total++;
    if ({busy, score_ready, result_valid, err_overrun, err_timeout} !== 5'b0)
      $display("FAIL reset_flags: got %b exp 00000",
        {busy, score_ready, result_valid, err_overrun, err_timeout});
    else n_pass++;
    n_total++;
    if (result_class !== '0 || result_score !== '0 || image_count !== '0)
      $display("FAIL reset_data: got %0d/%0d/%0d exp 0/0/0",
        result_class, result_score, image_count);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL reset_idle: busy %b exp 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic;
    int v [NUM_CLASSES] = '{5, -3, 12, 7, 0, -20, 99, 4, 1, 2};
    int lat;
    result_ready = 1'b1;
    start_img();
    n_total++;
    if (busy !== 1'b1 || score_ready !== 1'b1)
      $display("FAIL basic_collect: busy %b ready %b exp 1 1",
        busy, score_ready);
    else n_pass++;
    send(to_s(v), 1'b0);
    wait_rv(lat);
    n_total++;
    if (lat !== 6)
      $display("FAIL basic_latency: got %0d exp 6", lat);
    else n_pass++;
    n_total++;
    if (result_class !== 4'd6 || result_score !== score_t'(99))
      $display("FAIL basic_result: got %0d/%0d exp 6/99",
        result_class, result_score);
    else n_pass++;
    tick();
    n_total++;
    if (result_valid !== 1'b0 || image_count !== 16'd1 || busy !== 1'b0)
      $display("FAIL basic_xfer: rv %b cnt %0d busy %b exp 0 1 0",
        result_valid, image_count, busy);
    else n_pass++;
  endtask

  task automatic test_allneg;
    int v [NUM_CLASSES] = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, -100};
    int lat;
    bit bad;
    result_ready = 1'b1;
    start_img();
    send(to_s(v), 1'b1);
    bad = 1'b0;
    lat = 0;
    while (result_valid !== 1'b1 && lat < 20) begin
      if (score_ready !== 1'b0) bad = 1'b1;
      tick();
      lat++;
    end
    if (score_ready !== 1'b0) bad = 1'b1;
    n_total++;
    if (bad !== 1'b0)
      $display("FAIL allneg_ready: got high exp low outside COLLECT");
    else n_pass++;
    n_total++;
    if (result_valid !== 1'b1 || result_class !== 4'd8 ||
        result_score !== score_t'(-1))
      $display("FAIL allneg_result: got %b %0d/%0d exp 1 8/-1",
        result_valid, result_class, result_score);
    else n_pass++;
    tick();
    n_total++;
    if (image_count !== 16'd2)
      $display("FAIL allneg_count: got %0d exp 2", image_count);
    else n_pass++;
  endtask

  task automatic test_overrun;
    int v [NUM_CLASSES] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 5};
    int lat;
    result_ready = 1'b1;
    start_img();
    send(to_s(v), 1'b0);
    score_valid = 1'b1;
    score_in = score_t'(1000);
    n_total++;
    if (score_ready !== 1'b0)
      $display("FAIL ovr_ready: got %b exp 0", score_ready);
    else n_pass++;
    tick();
    score_valid = 1'b0;
    n_total++;
    if (err_overrun !== 1'b1)
      $display("FAIL ovr_flag: got %b exp 1", err_overrun);
    else n_pass++;
    wait_rv(lat);
    n_total++;
    if (result_valid !== 1'b1 || result_class !== 4'd8 ||
        result_score !== score_t'(90))
      $display("FAIL ovr_result: got %b %0d/%0d exp 1 8/90",
        result_valid, result_class, result_score);
    else n_pass++;
    tick();
    n_total++;
    if (err_overrun !== 1'b1 || image_count !== 16'd3)
      $display("FAIL ovr_sticky: got %b cnt %0d exp 1 3",
        err_overrun, image_count);
    else n_pass++;
    start_img();
    n_total++;
    if (err_overrun !== 1'b0)
      $display("FAIL ovr_clear: got %b exp 0", err_overrun);
    else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_hold;
    int v [NUM_CLASSES] = '{-1, 2, -3, 4, -5, 6, -7, 8, -9, 0};
    int lat;
    bit bad;
    result_ready = 1'b0;
    start_img();
    send(to_s(v), 1'b0);
    wait_rv(lat);
    bad = (lat < 0);
    repeat (20) begin
      tick();
      if (result_valid !== 1'b1 || result_class !== 4'd7 ||
          result_score !== score_t'(8) || image_count !== 16'd3)
        bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0)
      $display("FAIL hold_stable: got %b %0d/%0d cnt %0d exp 1 7/8 3",
        result_valid, result_class, result_score, image_count);
    else n_pass++;
    result_ready = 1'b1;
    tick();
    n_total++;
    if (result_valid !== 1'b0 || image_count !== 16'd4)
      $display("FAIL hold_xfer: rv %b cnt %0d exp 0 4",
        result_valid, image_count);
    else n_pass++;
  endtask

  task automatic test_abort;
    int v [NUM_CLASSES] = '{-50, -40, 30, -20, 31, -10, 0, 29, -60, -70};
    int lat;
    result_ready = 1'b1;
    start_img();
    for (int i = 0; i < 4; i++) begin
      score_valid = 1'b1;
      score_in = score_t'(500 + i);
      tick();
    end
    score_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++;
    if (busy !== 1'b0 || score_ready !== 1'b0 || image_count !== 16'd4)
      $display("FAIL abort_idle: busy %b rdy %b cnt %0d exp 0 0 4",
        busy, score_ready, image_count);
    else n_pass++;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL abort_prio: busy %b exp 0", busy);
    else n_pass++;
    start_img();
    send(to_s(v), 1'b0);
    wait_rv(lat);
    n_total++;
    if (result_class !== 4'd4 || result_score !== score_t'(31))
      $display("FAIL abort_next: got %0d/%0d exp 4/31",
        result_class, result_score);
    else n_pass++;
    tick();
    n_total++;
    if (image_count !== 16'd5)
      $display("FAIL abort_count: got %0d exp 5", image_count);
    else n_pass++;
  endtask

  task automatic test_extremes;
    score_arr_t s;
    score_t maxv;
    score_t minv;
    int lat;
    maxv = {1'b0, {(DATA_W-1){1'b1}}};
    minv = {1'b1, {(DATA_W-1){1'b0}}};
    for (int i = 0; i < NUM_CLASSES; i++)
      s[i] = score_t'(i - 4);
    s[0] = minv;
    s[3] = maxv - score_t'(1);
    s[9] = maxv;
    result_ready = 1'b1;
    start_img();
    send(s, 1'b0);
    wait_rv(lat);
    n_total++;
    if (result_class !== 4'd9 || result_score !== maxv)
      $display("FAIL extreme_result: got %0d/%0d exp 9/%0d",
        result_class, result_score, maxv);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back;
    int a [NUM_CLASSES] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    int b [NUM_CLASSES] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int lat;
    int t0;
    result_ready = 1'b1;
    start_img();
    t0 = cyc;
    send(to_s(a), 1'b0);
    wait_rv(lat);
    n_total++;
    if (result_class !== 4'd0 || result_score !== score_t'(9))
      $display("FAIL b2b_first: got %0d/%0d exp 0/9",
        result_class, result_score);
    else n_pass++;
    tick();
    start_img();
    n_total++;
    if (busy !== 1'b1 || score_ready !== 1'b1 || cyc - t0 !== 18)
      $display("FAIL b2b_start: busy %b rdy %b period %0d exp 1 1 18",
        busy, score_ready, cyc - t0);
    else n_pass++;
    send(to_s(b), 1'b0);
    wait_rv(lat);
    n_total++;
    if (result_class !== 4'd9 || result_score !== score_t'(9))
      $display("FAIL b2b_second: got %0d/%0d exp 9/9",
        result_class, result_score);
    else n_pass++;
    tick();
    n_total++;
    if (image_count !== 16'd8)
      $display("FAIL b2b_count: got %0d exp 8", image_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait;
    int v [NUM_CLASSES] = '{5, -3, 12, 7, 0, -20, 99, 4, 1, 2};
    result_ready = 1'b1;
    start_img();
    send(to_s(v), 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_total++;
    if ({busy, score_ready, result_valid, err_overrun, err_timeout} !== 5'b0 ||
        image_count !== 16'd0 || result_class !== '0 || result_score !== '0)
      $display("FAIL rst_async: flags %b cnt %0d res %0d/%0d exp 0",
        {busy, score_ready, result_valid, err_overrun, err_timeout},
        image_count, result_class, result_score);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    n_total++;
    if (result_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_stale: rv %b busy %b exp 0 0",
        result_valid, busy);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int v [NUM_CLASSES] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    force dut.am_done = 1'b0;
    result_ready = 1'b1;
    start_img();
    send(to_s(v), 1'b0);
    repeat (8) tick();
    n_total++;
    if (busy !== 1'b1 || err_timeout !== 1'b0)
      $display("FAIL tmo_early: busy %b tmo %b exp 1 0",
        busy, err_timeout);
    else n_pass++;
    tick();
    n_total++;
    if (busy !== 1'b0 || err_timeout !== 1'b1 || result_valid !== 1'b0 ||
        image_count !== 16'd0)
      $display("FAIL tmo_fire: busy %b tmo %b rv %b cnt %0d exp 0 1 0 0",
        busy, err_timeout, result_valid, image_count);
    else n_pass++;
    release dut.am_done;
    start_img();
    n_total++;
    if (err_timeout !== 1'b0)
      $display("FAIL tmo_clear: got %b exp 0", err_timeout);
    else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_allneg();
    test_overrun();
    test_hold();
    test_abort();
    test_extremes();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
